// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared state encoding and default widths for the memory stage
package mem_stage_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;
  localparam int MAX_WAIT_DEF = 15;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks an outstanding memory access, its wait count, timeout and pipeline stall
module mem_wait_fsm
  import mem_stage_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req,
  input  logic   done,
  output state_t state,
  output logic   timeout,
  output logic   stall_out
);
  logic [CNT_W-1:0] wait_cnt;
  logic             at_max;
  always_comb begin
    at_max = wait_cnt == CNT_W'(MAX_WAIT);
    timeout = state == WAIT && at_max && !done;
    stall_out = rst_n && (state == IDLE ? req && !done : !done && !at_max);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      state <= req && !done ? WAIT : IDLE;
      wait_cnt <= '0;
    end else begin
      state <= done || at_max ? IDLE : WAIT;
      wait_cnt <= at_max ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage that issues data-memory accesses from EX/MEM and owns the MEM/WB latch
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exmem_valid,
  input  logic [DW-1:0] exmem_alu_out,
  input  logic [DW-1:0] exmem_st_data,
  input  logic          exmem_mem_rd,
  input  logic          exmem_mem_wr,
  input  logic          exmem_reg_wr,
  input  logic [RW-1:0] exmem_dst,
  input  logic          exmem_halt,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_en,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_stall,
  input  logic          mem_done,
  output logic          stall_out,
  output logic          memwb_valid,
  output logic [DW-1:0] memwb_wb_data,
  output logic          memwb_reg_wr,
  output logic [RW-1:0] memwb_dst,
  output logic          memwb_halt,
  output logic          err
);
  state_t        state;
  logic          mem_op, unaligned, conflict, is_ld, is_st, req, ack, in_wait, timeout;
  logic [DW-1:0] addr_q, wdata_q;
  logic          wr_q, valid_q, reg_wr_q, halt_q;
  always_comb begin
    mem_op = exmem_valid && (exmem_mem_rd || exmem_mem_wr) && !exmem_halt;
    unaligned = mem_op && exmem_alu_out[0];
    conflict = mem_op && exmem_mem_rd && exmem_mem_wr;
    is_st = mem_op && exmem_mem_wr;
    is_ld = mem_op && !exmem_mem_wr;
    req = mem_op && !unaligned;
    ack = mem_done && !mem_stall;
    in_wait = state == WAIT;
    mem_en = rst_n && (in_wait || req);
    mem_wr = mem_en && (in_wait ? wr_q : is_st);
    mem_addr = !mem_en ? '0 : in_wait ? addr_q : exmem_alu_out;
    mem_wdata = !mem_en ? '0 : in_wait ? wdata_q : exmem_st_data;
  end
  mem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(ack),
    .state(state),
    .timeout(timeout),
    .stall_out(stall_out)
  );
  // request is frozen at issue so a waiting access presents identical address/data/direction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
    end else if (!in_wait && req) begin
      addr_q <= exmem_alu_out;
      wdata_q <= exmem_st_data;
      wr_q <= is_st;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      memwb_wb_data <= '0;
      reg_wr_q <= 1'b0;
      memwb_dst <= '0;
      halt_q <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= err || (!in_wait && (unaligned || conflict)) || timeout;
      if (stall_out) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= exmem_valid && !unaligned && !timeout;
        memwb_wb_data <= is_ld ? mem_rdata : exmem_alu_out;
        reg_wr_q <= exmem_reg_wr && !is_st;
        memwb_dst <= exmem_dst;
        halt_q <= exmem_halt;
      end
    end
  end
  assign memwb_valid = valid_q;
  assign memwb_reg_wr = reg_wr_q && valid_q;
  assign memwb_halt = halt_q && valid_q;
endmodule
